// File: rtl/conv_host_interface.sv
// Host-side register/buffer interface for the convolution core: decodes ipm
// strobes into X/Y operand buffers, Z result buffer, config and status.
module conv_host_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int CONF_WIDTH = 5,
  parameter int X_DEPTH    = 32,
  parameter int Y_DEPTH    = 32,
  parameter int Z_DEPTH    = 64
) (
  input  logic                       clk,
  input  logic                       rst_a,
  input  logic                       en_s,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  input  logic [CONF_WIDTH-1:0]      conf_dbus,
  input  logic                       write,
  input  logic                       read,
  input  logic                       start,
  output logic                       int_req,
  output logic                       core_start,
  output logic [5:0]                 core_size_x,
  output logic [5:0]                 core_size_y,
  input  logic [$clog2(X_DEPTH)-1:0] core_x_addr,
  output logic [DATA_WIDTH-1:0]      core_x_data,
  input  logic [$clog2(Y_DEPTH)-1:0] core_y_addr,
  output logic [DATA_WIDTH-1:0]      core_y_data,
  input  logic                       core_z_we,
  input  logic [$clog2(Z_DEPTH)-1:0] core_z_addr,
  input  logic [DATA_WIDTH-1:0]      core_z_data,
  input  logic                       core_done
);
  // state | meaning
  // IDLE  | host owns buffers and config; start accepted if sizes valid
  // RUN   | core owns the operation; host buffer/config access blocked
  localparam int XA = $clog2(X_DEPTH);
  localparam int YA = $clog2(Y_DEPTH);
  localparam int ZA = $clog2(Z_DEPTH);

  localparam logic [CONF_WIDTH-1:0] SEL_WR_X    = CONF_WIDTH'(0);
  localparam logic [CONF_WIDTH-1:0] SEL_WR_Y    = CONF_WIDTH'(1);
  localparam logic [CONF_WIDTH-1:0] SEL_RD_Z    = CONF_WIDTH'(2);
  localparam logic [CONF_WIDTH-1:0] SEL_CFG     = CONF_WIDTH'(3);
  localparam logic [CONF_WIDTH-1:0] SEL_STATUS  = CONF_WIDTH'(4);
  localparam logic [CONF_WIDTH-1:0] SEL_PTR_RST = CONF_WIDTH'(5);

  localparam logic [5:0] X_MAX = 6'(X_DEPTH);
  localparam logic [5:0] Y_MAX = 6'(Y_DEPTH);

  typedef enum logic {IDLE, RUN} fsmState;
  fsmState state, stateNext;

  logic [DATA_WIDTH-1:0] xMem [X_DEPTH];
  logic [DATA_WIDTH-1:0] yMem [Y_DEPTH];
  logic [DATA_WIDTH-1:0] zMem [Z_DEPTH];

  logic [XA-1:0] px;
  logic [YA-1:0] py;
  logic [ZA-1:0] pz;
  logic [5:0] sizeX, sizeY;
  logic intEn, done, err, busy;
  logic startPulse, setErr, setDone, sizeOk;
  logic wrStrobe, wrX, wrY, wrCfg, wrStatusClr, wrPtrRst, rdZ;
  logic [DATA_WIDTH-1:0] rdData;

  assign busy   = (state == RUN);
  assign sizeOk = (sizeX != 6'd0) && (sizeX <= X_MAX) && (sizeY != 6'd0) && (sizeY <= Y_MAX);

  assign wrStrobe    = en_s && write;
  assign wrX         = wrStrobe && (conf_dbus == SEL_WR_X) && !busy;
  assign wrY         = wrStrobe && (conf_dbus == SEL_WR_Y) && !busy;
  assign wrCfg       = wrStrobe && (conf_dbus == SEL_CFG) && !busy;
  assign wrStatusClr = wrStrobe && (conf_dbus == SEL_STATUS) && data_in[0];
  assign wrPtrRst    = wrStrobe && (conf_dbus == SEL_PTR_RST);
  assign rdZ         = en_s && read && (conf_dbus == SEL_RD_Z) && !busy;

  assign core_x_data = xMem[core_x_addr];
  assign core_y_data = yMem[core_y_addr];

  always_comb begin
    rdData = '0;
    case (conf_dbus)
      SEL_RD_Z:   if (!busy) rdData = zMem[pz];
      SEL_CFG: begin
        rdData[5:0]  = sizeX;
        rdData[13:8] = sizeY;
        rdData[16]   = intEn;
      end
      SEL_STATUS: rdData[3:0] = {err, intEn, done, busy};
      default:    rdData = '0;
    endcase
  end

  always_comb begin
    stateNext  = state;
    startPulse = 1'b0;
    setErr     = 1'b0;
    setDone    = 1'b0;
    case (state)
      IDLE: begin
        if (en_s && start) begin
          if (sizeOk) begin
            stateNext  = RUN;
            startPulse = 1'b1;
          end else begin
            setErr = 1'b1;
          end
        end
      end
      RUN: begin
        if (en_s && core_done) begin
          stateNext = IDLE;
          setDone   = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= IDLE;
    else if (en_s) state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      data_out    <= '0;
      int_req     <= 1'b0;
      core_start  <= 1'b0;
      core_size_x <= '0;
      core_size_y <= '0;
      px          <= '0;
      py          <= '0;
      pz          <= '0;
      sizeX       <= '0;
      sizeY       <= '0;
      intEn       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else if (en_s) begin
      core_start <= startPulse;
      // start samples the pre-write cfg, so a same-cycle CFG write applies to the next run
      if (startPulse) begin
        core_size_x <= sizeX;
        core_size_y <= sizeY;
      end
      if (wrCfg) begin
        sizeX <= data_in[5:0];
        sizeY <= data_in[13:8];
        intEn <= data_in[16];
      end
      if (wrPtrRst) begin
        px <= '0;
        py <= '0;
      end else begin
        if (wrX) px <= px + XA'(1);
        if (wrY) py <= py + YA'(1);
      end
      if (startPulse || wrPtrRst) pz <= '0;
      else if (rdZ) pz <= pz + ZA'(1);
      if (read) data_out <= rdData;
      // completion beats a coincident host clear
      if (setDone) done <= 1'b1;
      else if (wrStatusClr) done <= 1'b0;
      if (setErr) err <= 1'b1;
      else if (wrStatusClr) err <= 1'b0;
      if (setDone && intEn) int_req <= 1'b1;
      else if (wrStatusClr) int_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wrX) xMem[px] <= data_in;
    if (wrY) yMem[py] <= data_in;
    if (en_s && core_z_we) zMem[core_z_addr] <= core_z_data;
  end
endmodule
